// File: rtl/pkt_mux_n_if.sv
// Packet mux bus bundle: N flattened input flit ports, one registered output
// port, arbitration select and status.
interface pkt_mux_n_if #(
  parameter int N     = 4,
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int SELW  = 3
) ();
  logic [N*DATAW-1:0] idata;
  logic [N-1:0]       ivalid;
  logic [N*VCHW-1:0]  ivch;
  logic [N-1:0]       iready;
  logic [SELW-1:0]    sel;
  logic [DATAW-1:0]   odata;
  logic               ovalid;
  logic [VCHW-1:0]    ovch;
  logic               oready;
  logic [N-1:0]       grant;
  logic [15:0]        pkt_cnt;

  modport slave (
    input  idata, ivalid, ivch, sel, oready,
    output iready, odata, ovalid, ovch, grant, pkt_cnt
  );

  modport master (
    output idata, ivalid, ivch, sel, oready,
    input  iready, odata, ovalid, ovch, grant, pkt_cnt
  );
endinterface

// File: rtl/pkt_mux_n.sv
// N:1 packet multiplexer: arbitrates on HEAD flits, locks the output to the
// winning port until its TAIL, and drives one registered valid/ready stage.
module pkt_mux_n #(
  parameter int N     = 4,
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int SELW  = 3,
  parameter int MODE  = 1
) (
  input logic        clk,
  input logic        rst_,
  pkt_mux_n_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {FT_NONE, FT_HEAD, FT_DATA, FT_TAIL} flit_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [DATAW-1:0] odata_q, odata_d;
  logic [VCHW-1:0]  ovch_q, ovch_d;
  logic             ovalid_q, ovalid_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [PW-1:0]    lock_q, lock_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [1:0]       ftype [N];
  logic [N-1:0]     cand;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cur_idx;
  logic [1:0]       cur_type;
  logic [N-1:0]     iready;
  logic             ld;
  logic             xfer;

  for (genvar k = 0; k < N; k++) begin : g_type
    assign ftype[k] = bus.idata[k*DATAW + DATAW - 2 +: 2];
    assign cand[k]  = bus.ivalid[k] && (ftype[k] == FT_HEAD);
  end

  assign ld       = !ovalid_q || bus.oready;
  assign cur_idx  = (state_q == IDLE) ? win_idx : lock_q;
  assign cur_type = ftype[cur_idx];
  assign xfer     = bus.ivalid[cur_idx] && iready[cur_idx];

  // Arbitration among HEAD candidates: round-robin from rr_ptr or external sel
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (MODE == 1) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!win_vld && cand[(32'(rr_ptr_q) + i) % N]) begin
          win_vld = 1'b1;
          win_idx = PW'((32'(rr_ptr_q) + i) % N);
        end
      end
    end else begin
      if ((32'(bus.sel) < N) && cand[bus.sel[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = bus.sel[PW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: lock on an accepted HEAD, unlock on an accepted TAIL
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = LOCKED;
      LOCKED:  if (xfer && cur_type == FT_TAIL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-port accept: only the arbitration winner or the locked port may move
  always_comb begin
    iready = '0;
    if (rst_) begin
      if (state_q == IDLE) begin
        if (win_vld && ld) iready[win_idx] = 1'b1;
      end else begin
        iready[lock_q] = ld;
      end
    end
  end

  // Datapath next values; NONE flits are consumed without reaching the output
  always_comb begin
    odata_d   = odata_q;
    ovch_d    = ovch_q;
    ovalid_d  = ovalid_q;
    grant_d   = grant_q;
    pkt_cnt_d = pkt_cnt_q;
    lock_d    = lock_q;
    rr_ptr_d  = rr_ptr_q;
    if (ld) begin
      ovalid_d = 1'b0;
      if (xfer && cur_type != FT_NONE) begin
        ovalid_d = 1'b1;
        odata_d  = bus.idata[32'(cur_idx)*DATAW +: DATAW];
        ovch_d   = bus.ivch[32'(cur_idx)*VCHW +: VCHW];
      end
    end
    if (xfer && state_q == IDLE) begin
      lock_d           = cur_idx;
      grant_d          = '0;
      grant_d[cur_idx] = 1'b1;
    end
    if (xfer && state_q == LOCKED && cur_type == FT_TAIL) begin
      grant_d   = '0;
      pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (MODE == 1) rr_ptr_d = PW'((32'(lock_q) + 1) % N);
    end
  end

  // Datapath and bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_) begin
      odata_q   <= '0;
      ovch_q    <= '0;
      ovalid_q  <= 1'b0;
      grant_q   <= '0;
      pkt_cnt_q <= '0;
      lock_q    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      odata_q   <= odata_d;
      ovch_q    <= ovch_d;
      ovalid_q  <= ovalid_d;
      grant_q   <= grant_d;
      pkt_cnt_q <= pkt_cnt_d;
      lock_q    <= lock_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.iready  = iready;
  assign bus.odata   = odata_q;
  assign bus.ovch    = ovch_q;
  assign bus.ovalid  = ovalid_q;
  assign bus.grant   = grant_q;
  assign bus.pkt_cnt = pkt_cnt_q;
endmodule

// File: tb/tb_pkt_mux_n.sv
// Bench for pkt_mux_n: a round-robin instance (index 0) and an external-select
// instance (index 1) fed from per-port flit queues and compared every cycle
// against a behavioural model of the packet-locking rules.
module tb_pkt_mux_n;
  localparam int N  = 4;
  localparam int DW = 66;
  localparam int VW = 2;
  localparam int SW = 3;

  typedef logic [DW+VW-1:0] ent_t;

  logic clk;
  logic rst_;

  pkt_mux_n_if #(.N(N), .DATAW(DW), .VCHW(VW), .SELW(SW)) if_rr ();
  pkt_mux_n_if #(.N(N), .DATAW(DW), .VCHW(VW), .SELW(SW)) if_sel ();

  pkt_mux_n #(.N(N), .DATAW(DW), .VCHW(VW), .SELW(SW), .MODE(1)) u_rr (
    .clk(clk), .rst_(rst_), .bus(if_rr)
  );
  pkt_mux_n #(.N(N), .DATAW(DW), .VCHW(VW), .SELW(SW), .MODE(0)) u_sel (
    .clk(clk), .rst_(rst_), .bus(if_sel)
  );

  // stimulus
  logic [DW-1:0] in_data [2][N];
  logic [VW-1:0] in_vch  [2][N];
  logic [N-1:0]  in_vld  [2];
  logic [SW-1:0] in_sel  [2];
  logic          in_ordy [2];
  ent_t          srcq    [2][N][$];
  int            gap_pct;

  // observed
  logic [N-1:0]  o_iready [2];
  logic [DW-1:0] o_odata  [2];
  logic          o_ovalid [2];
  logic [VW-1:0] o_ovch   [2];
  logic [N-1:0]  o_grant  [2];
  logic [15:0]   o_cnt    [2];

  for (genvar k = 0; k < N; k++) begin : g_drv
    assign if_rr.idata[k*DW +: DW]  = in_data[0][k];
    assign if_sel.idata[k*DW +: DW] = in_data[1][k];
    assign if_rr.ivch[k*VW +: VW]   = in_vch[0][k];
    assign if_sel.ivch[k*VW +: VW]  = in_vch[1][k];
  end
  assign if_rr.ivalid  = in_vld[0];
  assign if_sel.ivalid = in_vld[1];
  assign if_rr.sel     = in_sel[0];
  assign if_sel.sel    = in_sel[1];
  assign if_rr.oready  = in_ordy[0];
  assign if_sel.oready = in_ordy[1];

  assign o_iready[0] = if_rr.iready;   assign o_iready[1] = if_sel.iready;
  assign o_odata[0]  = if_rr.odata;    assign o_odata[1]  = if_sel.odata;
  assign o_ovalid[0] = if_rr.ovalid;   assign o_ovalid[1] = if_sel.ovalid;
  assign o_ovch[0]   = if_rr.ovch;     assign o_ovch[1]   = if_sel.ovch;
  assign o_grant[0]  = if_rr.grant;    assign o_grant[1]  = if_sel.grant;
  assign o_cnt[0]    = if_rr.pkt_cnt;  assign o_cnt[1]    = if_sel.pkt_cnt;

  // reference model state
  bit            m_lock   [2];
  int            m_lport  [2];
  int            m_rr     [2];
  logic [DW-1:0] m_odata  [2];
  logic          m_ovalid [2];
  logic [VW-1:0] m_ovch   [2];
  logic [15:0]   m_cnt    [2];
  logic [N-1:0]  m_rdy    [2];

  // monitors
  int            nout [2];
  int            nacc [2];
  logic [N-1:0]  last_g [2];
  logic [N-1:0]  gseq [2][$];
  bit            prev_stall [2];
  logic [DW-1:0] prev_od [2];

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_head(int m, int p);
    return in_vld[m][p] && (in_data[m][p][DW-1:DW-2] == 2'b01);
  endfunction

  function automatic logic [N-1:0] exp_grant(int m);
    logic [N-1:0] g = '0;
    if (m_lock[m]) g[m_lport[m]] = 1'b1;
    return g;
  endfunction

  // which port the mux is allowed to accept from this cycle
  function automatic logic [N-1:0] exp_ready(int m);
    logic [N-1:0] r  = '0;
    bit           ld = !m_ovalid[m] || in_ordy[m];
    if (!rst_) return '0;
    if (m_lock[m]) begin
      r[m_lport[m]] = ld;
      return r;
    end
    if (!ld) return '0;
    if (m == 0) begin
      for (int i = 0; i < N; i++) begin
        if (is_head(m, (m_rr[m] + i) % N)) begin
          r[(m_rr[m] + i) % N] = 1'b1;
          return r;
        end
      end
    end else if (int'(in_sel[m]) < N && is_head(m, int'(in_sel[m]))) begin
      r[in_sel[m]] = 1'b1;
    end
    return r;
  endfunction

  task automatic step(int m);
    bit         ld = !m_ovalid[m] || in_ordy[m];
    int         p  = -1;
    logic [1:0] t  = 2'b00;
    if (!rst_) begin
      m_lock[m] = 0; m_lport[m] = 0; m_rr[m] = 0;
      m_odata[m] = '0; m_ovalid[m] = 1'b0; m_ovch[m] = '0; m_cnt[m] = '0;
      return;
    end
    for (int k = 0; k < N; k++) if (m_rdy[m][k] && in_vld[m][k]) p = k;
    if (p >= 0) begin
      t = in_data[m][p][DW-1:DW-2];
      void'(srcq[m][p].pop_front());
      nacc[m]++;
    end
    if (ld) begin
      if (p >= 0 && t != 2'b00) begin
        m_odata[m]  = in_data[m][p];
        m_ovch[m]   = in_vch[m][p];
        m_ovalid[m] = 1'b1;
      end else begin
        m_ovalid[m] = 1'b0;
      end
    end
    if (p >= 0) begin
      if (!m_lock[m]) begin
        m_lock[m]  = 1;
        m_lport[m] = p;
      end else if (t == 2'b11) begin
        m_lock[m] = 0;
        m_cnt[m]  = m_cnt[m] + 16'd1;
        if (m == 0) m_rr[m] = (p + 1) % N;
      end
    end
  endtask

  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < N; k++) begin
        if (srcq[m][k].size() > 0) begin
          in_data[m][k] = srcq[m][k][0][DW-1:0];
          in_vch[m][k]  = srcq[m][k][0][DW+VW-1:DW];
          in_vld[m][k]  = ($urandom_range(99) >= gap_pct);
        end else begin
          in_data[m][k] = '0;
          in_vch[m][k]  = '0;
          in_vld[m][k]  = 1'b0;
        end
      end
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("odata%0d", m), o_odata[m], m_odata[m]);
      chk($sformatf("ovalid%0d", m), o_ovalid[m], m_ovalid[m]);
      chk($sformatf("ovch%0d", m), o_ovch[m], m_ovch[m]);
      chk($sformatf("grant%0d", m), o_grant[m], exp_grant(m));
      chk($sformatf("pkt_cnt%0d", m), o_cnt[m], m_cnt[m]);
      m_rdy[m] = exp_ready(m);
      chk($sformatf("iready%0d", m), o_iready[m], m_rdy[m]);
      if (prev_stall[m]) chk($sformatf("stall_hold%0d", m), o_odata[m], prev_od[m]);
      if (o_ovalid[m] === 1'b1 && !in_ordy[m])
        chk($sformatf("stall_iready%0d", m), o_iready[m], '0);
      prev_stall[m] = (o_ovalid[m] === 1'b1) && !in_ordy[m] && rst_;
      prev_od[m]    = o_odata[m];
      if (o_ovalid[m] === 1'b1 && in_ordy[m]) nout[m]++;
      if (o_grant[m] != '0 && o_grant[m] != last_g[m]) gseq[m].push_back(o_grant[m]);
      last_g[m] = o_grant[m];
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) step(m);
  endtask

  task automatic push_pkt(int m, int p, int nd, bit mix);
    logic [VW-1:0] v = VW'($urandom_range(3));
    logic [1:0]    t;
    for (int i = 0; i < nd + 2; i++) begin
      t = 2'b10;
      if (i == 0) t = 2'b01;
      else if (i == nd + 1) t = 2'b11;
      else if (mix) begin
        case ($urandom_range(9))
          0: t = 2'b00;
          1: t = 2'b01;
          default: t = 2'b10;
        endcase
      end
      srcq[m][p].push_back({v, t, 32'($urandom), 32'($urandom)});
    end
  endtask

  function automatic bit all_idle();
    bit r = 1;
    for (int m = 0; m < 2; m++) begin
      if (m_lock[m] || m_ovalid[m]) r = 0;
      for (int k = 0; k < N; k++) if (srcq[m][k].size() != 0) r = 0;
    end
    return r;
  endfunction

  task automatic drain(int maxc);
    int c = 0;
    while (!all_idle() && c < maxc) begin
      if (!m_lock[1])
        for (int k = N - 1; k >= 0; k--) if (srcq[1][k].size() != 0) in_sel[1] = SW'(k);
      tick();
      c++;
    end
    chk("drain_done", 128'(all_idle()), 128'(1));
  endtask

  task automatic clear_queues();
    for (int m = 0; m < 2; m++) for (int k = 0; k < N; k++) srcq[m][k].delete();
  endtask

  initial begin
    int base;
    int n0;
    int c;
    logic [N-1:0] exp_seq [6];
    logic [3:0]   bp_pat;

    n_tests = 0;
    n_fail  = 0;
    gap_pct = 0;
    rst_    = 1'b0;
    for (int m = 0; m < 2; m++) begin
      in_sel[m] = '0; in_ordy[m] = 1'b1; in_vld[m] = '0;
      nout[m] = 0; nacc[m] = 0; last_g[m] = '0; prev_stall[m] = 0; prev_od[m] = '0;
      m_lock[m] = 0; m_lport[m] = 0; m_rr[m] = 0; m_odata[m] = '0;
      m_ovalid[m] = 1'b0; m_ovch[m] = '0; m_cnt[m] = '0; m_rdy[m] = '0;
      for (int k = 0; k < N; k++) begin in_data[m][k] = '0; in_vch[m][k] = '0; end
    end
    repeat (2) @(posedge clk);
    #1;

    // reset with HEADs offered on every port
    for (int k = 0; k < N; k++) push_pkt(0, k, 1, 0);
    push_pkt(1, 0, 1, 0);
    repeat (2) tick();
    chk("rst_iready", o_iready[0], '0);
    chk("rst_grant", o_grant[0], '0);
    rst_ = 1'b1;
    drain(100);
    chk("rst_rr_cnt", o_cnt[0], 16'd4);
    chk("rst_sel_cnt", o_cnt[1], 16'd1);

    // single 22-flit packet on port 2
    base = int'(o_cnt[0]);
    n0   = nout[0];
    push_pkt(0, 2, 20, 0);
    repeat (3) tick();
    chk("single_grant", o_grant[0], 4'b0100);
    drain(100);
    chk("single_nflits", 128'(nout[0] - n0), 128'(22));
    chk("single_cnt", o_cnt[0], 16'(base + 1));
    chk("single_grant_idle", o_grant[0], '0);

    // round-robin fairness from a fresh rr_ptr
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    gseq[0].delete();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 0, 1, 0); push_pkt(0, 1, 1, 0); push_pkt(0, 3, 1, 0);
    end
    drain(200);
    exp_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    chk("rr_nseq", 128'(gseq[0].size()), 128'(6));
    for (int i = 0; i < 6 && i < gseq[0].size(); i++)
      chk($sformatf("rr_order%0d", i), gseq[0][i], exp_seq[i]);
    chk("rr_cnt", o_cnt[0], 16'd6);

    // backpressure on a port 1 packet
    n0     = nout[0];
    bp_pat = 4'b1001;
    push_pkt(0, 1, 4, 0);
    c = 0;
    while (!all_idle() && c < 60) begin
      in_ordy[0] = bp_pat[c % 4];
      tick();
      c++;
    end
    in_ordy[0] = 1'b1;
    drain(50);
    chk("bp_nflits", 128'(nout[0] - n0), 128'(6));

    // external select: sel ignored while locked, out-of-range sel grants nothing
    gseq[1].delete();
    in_sel[1] = 3'd1;
    push_pkt(1, 0, 3, 0);
    push_pkt(1, 1, 6, 0);
    repeat (3) tick();
    chk("sel_grant1", o_grant[1], 4'b0010);
    in_sel[1] = 3'd0;
    repeat (3) tick();
    chk("sel_hold1", o_grant[1], 4'b0010);
    drain(100);
    chk("sel_nseq", 128'(gseq[1].size()), 128'(2));
    if (gseq[1].size() == 2) begin
      chk("sel_order0", gseq[1][0], 4'b0010);
      chk("sel_order1", gseq[1][1], 4'b0001);
    end
    in_sel[1] = 3'd5;
    push_pkt(1, 2, 2, 0);
    repeat (4) tick();
    chk("sel_oob_grant", o_grant[1], '0);
    chk("sel_oob_iready", o_iready[1], '0);
    srcq[1][2].delete();
    in_sel[1] = 3'd0;

    // reset mid-packet after HEAD + 5 DATA accepted
    n0 = nacc[0];
    push_pkt(0, 2, 10, 0);
    c = 0;
    while (nacc[0] - n0 < 6 && c < 50) begin tick(); c++; end
    chk("mid_accepted", 128'(nacc[0] - n0), 128'(6));
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    clear_queues();
    tick();
    chk("mid_grant", o_grant[0], '0);
    chk("mid_ovalid", o_ovalid[0], 1'b0);
    push_pkt(0, 3, 2, 0);
    drain(50);
    chk("mid_cnt", o_cnt[0], 16'd1);

    // randomized traffic with mixed middle flits and random backpressure/sel
    gap_pct = 20;
    for (int i = 0; i < 2000; i++) begin
      for (int m = 0; m < 2; m++) begin
        int p = $urandom_range(N - 1);
        in_ordy[m] = ($urandom_range(99) < 70);
        if ($urandom_range(9) == 0 && srcq[m][p].size() < 20)
          push_pkt(m, p, $urandom_range(5), 1);
      end
      if ($urandom_range(4) == 0) in_sel[1] = SW'($urandom_range(7));
      tick();
    end
    gap_pct    = 0;
    in_ordy[0] = 1'b1;
    in_ordy[1] = 1'b1;
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_mux_n.md
Name: pkt_mux_n

Overview:
- Parametrised N:1 packet multiplexer for the NoC router output stage; next generation of the 2:1 combinational mux.
- Arbitrates among N input ports and locks the output to one input for a whole packet (HEAD..TAIL).
- Drives one registered output stage with valid/ready backpressure.
- MODE selects external select or internal round-robin arbitration.

Parameters:
- N, 4, number of input ports (2..8)
- DATAW, 66, flit width in bits; flit type is idata[DATAW-1:DATAW-2]
- VCHW, 2, virtual-channel id width
- SELW, 3, width of sel; must satisfy 2^SELW >= N
- MODE, 1, 0 = external sel, 1 = round-robin on HEAD flits
- Flit type encoding: NONE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11

Ports:
- clk  in  1  system clock, rising edge
- rst_  in  1  synchronous active-low reset
- idata  in  N*DATAW  flattened input flits; port k at [k*DATAW +: DATAW]
- ivalid  in  N  per-port flit valid
- ivch  in  N*VCHW  per-port VC id
- iready  out  N  per-port accept; a transfer occurs when ivalid[k]&iready[k]
- sel  in  SELW  port select; used only when MODE=0, sampled on HEAD
- odata  out  DATAW  registered output flit
- ovalid  out  1  output valid
- ovch  out  VCHW  registered output VC id
- oready  in  1  downstream accept
- grant  out  N  one-hot locked port; 0 when idle
- pkt_cnt  out  16  count of TAIL flits forwarded; wraps at 16'hFFFF->0

Behaviour:
- Reset (rst_=0 at a clk edge): odata=0, ovalid=0, ovch=0, grant=0, pkt_cnt=0, state=IDLE, rr_ptr=0. iready=0 while reset is asserted. Reset mid-packet drops the packet and unlocks.
- Output register load condition: ld = !ovalid | oready. On a transfer, odata/ovch take the flit next edge and ovalid=1. If oready=1 with no transfer, ovalid clears to 0.
- Latency: 1 cycle input-to-output. Throughput: 1 flit/cycle when oready is held high.
- State IDLE:
  - Candidates are ports with ivalid=1 and type=HEAD.
  - MODE=1: the winner is the first candidate at or after rr_ptr, searching upward with wrap.
  - MODE=0: the winner is port sel, only if it is a candidate. sel>=N means no winner.
  - When a winner exists and ld=1: iready[winner]=1 and the HEAD transfers. grant becomes one-hot(winner) next edge. Go to LOCKED.
  - Non-HEAD flits arriving while IDLE are not accepted (iready=0) and stay stalled.
- State LOCKED:
  - iready[grant]=ld; all other iready bits are 0.
  - DATA and HEAD flits pass through. A HEAD arriving while LOCKED is forwarded as data; no re-arbitration.
  - TYPE NONE with ivalid=1 is accepted and discarded (not loaded into the output).
  - On a TAIL transfer: go to IDLE, grant=0, pkt_cnt+1. MODE=1: rr_ptr = granted port + 1 mod N.
- Packets on different ports never interleave at the output.
- ivalid deasserted mid-packet: stall in LOCKED indefinitely; the lock is held.
- oready=0 with ovalid=1: output holds, iready=0, no state change.
- A TAIL transfer and a new HEAD in the same cycle: the new HEAD is not accepted that cycle. Arbitration happens in the following IDLE cycle, which costs 1 bubble cycle per packet.
- sel changes while LOCKED: no effect.

Test Plan:
- Reset: hold rst_=0 for 2 cycles with all inputs driven -> ovalid=0, grant=0, pkt_cnt=0, iready=0; after release the first HEAD appears at the output 1 cycle after acceptance.
- Single packet, MODE=1: port 2 sends HEAD, 20 DATA, TAIL with oready=1 -> 22 flits out in order on consecutive cycles, grant=4'b0100 throughout, pkt_cnt=1, grant=0 after the TAIL.
- Round-robin fairness: ports 0, 1 and 3 each present HEAD continuously, 3-flit packets -> grant order 0,1,3,0,1,3; pkt_cnt=6 after 6 packets; one idle bubble between packets.
- Backpressure: oready toggles 1,0,0,1 during a port 1 packet -> odata held stable while oready=0, no flit lost or duplicated, iready[1]=0 in stall cycles.
- MODE=0: sel=1, ports 0 and 1 both offer HEAD -> port 1 granted. Change sel to 0 mid-packet -> the lock stays on port 1 until its TAIL. sel=5 with N=4 -> no grant.
- Reset mid-packet: assert rst_ after the HEAD and 5 DATA flits -> the next edge gives ovalid=0, grant=0, IDLE; a fresh HEAD is accepted normally afterwards.
